// File: rtl/simon_pkg.sv
// Shared types and default timing for the Simon sequence controller.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    WAIT_PRESS,
    WAIT_RELEASE,
    GAME_OVER,
    WIN
  } state_t;

  localparam int unsigned DEF_MAX_LEN       = 32;
  localparam int unsigned DEF_ON_TICKS      = 30;
  localparam int unsigned DEF_OFF_TICKS     = 15;
  localparam int unsigned DEF_TIMEOUT_TICKS = 180;
  localparam int unsigned LEVEL_W           = 6;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence storage: one 2-bit color per step, synchronous write, combinational read.
module simon_seq_mem import simon_pkg::*; #(
  parameter int unsigned DEPTH  = DEF_MAX_LEN,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [1:0]        wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [1:0]        rData
);

  // Contents are never cleared; only entries below the current level are read.
  color_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon game sequencer: appends a random step, replays the sequence, checks player input.
// Define SIMON_TIMEOUT_EN to end the game when the player stays idle for TIMEOUT_TICKS.
module simon_seq_ctrl import simon_pkg::*; #(
  parameter int unsigned MAX_LEN       = DEF_MAX_LEN,
  parameter int unsigned ON_TICKS      = DEF_ON_TICKS,
  parameter int unsigned OFF_TICKS     = DEF_OFF_TICKS,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] randNum,
  input  logic [1:0] playerNum,
  input  logic       playerPressed,
  output logic       simonTurn,
  output logic [1:0] simonNum,
  output logic       simonPressed,
  output logic [5:0] level,
  output logic       gameOver,
  output logic       win
);

  localparam int unsigned ADDR_W = $clog2(MAX_LEN);
  localparam int unsigned TICK_W = $clog2(max3(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS) + 1);

  state_t              state, nextState;
  logic [LEVEL_W-1:0]  levelQ;
  logic [ADDR_W-1:0]   idx;
  logic [TICK_W-1:0]   tick;
  logic                prevPressed;
  logic [1:0]          entry;
  logic                press, onDone, offDone, lastIdx, timeout;

  simon_seq_mem #(.DEPTH(MAX_LEN), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (state == ADD),
    .wAddr (ADDR_W'(levelQ)),
    .wData (randNum),
    .rAddr (idx),
    .rData (entry)
  );

  // Rising edge only, so a button held over from the replay never counts.
  assign press   = playerPressed & ~prevPressed;
  assign onDone  = (tick == TICK_W'(ON_TICKS - 1));
  assign offDone = (tick == TICK_W'(OFF_TICKS - 1));
  assign lastIdx = (LEVEL_W'(idx) == levelQ - LEVEL_W'(1));

`ifdef SIMON_TIMEOUT_EN
  assign timeout = (tick == TICK_W'(TIMEOUT_TICKS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, GAME_OVER, WIN: if (start) nextState = ADD;
      ADD:          nextState = SHOW_ON;
      SHOW_ON:      if (onDone) nextState = SHOW_OFF;
      SHOW_OFF:     if (offDone) nextState = lastIdx ? WAIT_PRESS : SHOW_ON;
      WAIT_PRESS: begin
        if (press)        nextState = (playerNum == entry) ? WAIT_RELEASE : GAME_OVER;
        else if (timeout) nextState = GAME_OVER;
      end
      WAIT_RELEASE: begin
        if (!playerPressed) begin
          if (!lastIdx)                          nextState = WAIT_PRESS;
          else if (levelQ == LEVEL_W'(MAX_LEN))  nextState = WIN;
          else                                   nextState = ADD;
        end
      end
      default:      nextState = IDLE;
    endcase
  end

  always_comb begin
    simonTurn    = 1'b0;
    simonPressed = 1'b0;
    simonNum     = 2'd0;
    gameOver     = 1'b0;
    win          = 1'b0;
    case (state)
      SHOW_ON: begin
        simonTurn    = 1'b1;
        simonPressed = 1'b1;
        simonNum     = entry;
      end
      SHOW_OFF:  simonTurn = 1'b1;
      GAME_OVER: gameOver  = 1'b1;
      WIN:       win       = 1'b1;
      default: ;
    endcase
  end

  // Level, step index, tick counter and press-edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      levelQ      <= '0;
      idx         <= '0;
      tick        <= '0;
      prevPressed <= 1'b0;
    end else begin
      prevPressed <= playerPressed;
      case (state)
        IDLE, GAME_OVER, WIN: if (start) levelQ <= '0;
        ADD: begin
          levelQ <= levelQ + LEVEL_W'(1);
          idx    <= '0;
          tick   <= '0;
        end
        SHOW_ON: tick <= onDone ? '0 : tick + TICK_W'(1);
        SHOW_OFF: begin
          if (offDone) begin
            tick <= '0;
            idx  <= lastIdx ? '0 : idx + ADDR_W'(1);
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
`ifdef SIMON_TIMEOUT_EN
        WAIT_PRESS: tick <= tick + TICK_W'(1);
`else
        WAIT_PRESS: tick <= '0;
`endif
        WAIT_RELEASE: begin
          if (!playerPressed && !lastIdx) begin
            idx  <= idx + ADDR_W'(1);
            tick <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign level = levelQ;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl; a MAX_LEN=2 instance shares the stimulus to reach WIN.
module tb_simon_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, playerPressed;
  logic [1:0] randNum, playerNum;
  logic       simonTurn, simonPressed, gameOver, win;
  logic [1:0] simonNum;
  logic [5:0] level;
  logic       s2Turn, s2Pressed, s2Over, s2Win;
  logic [1:0] s2Num;
  logic [5:0] s2Level;

  int tests = 0;
  int fails = 0;
  logic [1:0] seqQ [$];

  always #5 clk = ~clk;

  simon_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .randNum(randNum),
    .playerNum(playerNum), .playerPressed(playerPressed),
    .simonTurn(simonTurn), .simonNum(simonNum), .simonPressed(simonPressed),
    .level(level), .gameOver(gameOver), .win(win)
  );

  simon_seq_ctrl #(.MAX_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .randNum(randNum),
    .playerNum(playerNum), .playerPressed(playerPressed),
    .simonTurn(s2Turn), .simonNum(s2Num), .simonPressed(s2Pressed),
    .level(s2Level), .gameOver(s2Over), .win(s2Win)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Replays the scoreboard sequence against the lit/dark phases of dut.
  task automatic watchShow(input string tag);
    logic [1:0] expQ [$];
    logic [1:0] e;
    int n;
    expQ = seqQ;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      n = 0;
      while (!simonPressed && n < 60) begin step(); n++; end
      if (!simonPressed) begin
        check({tag, " lit_wait"}, 32'(simonPressed), 1);
        return;
      end
      check({tag, " color"}, 32'(simonNum), 32'(e));
      n = 0;
      while (simonPressed && n < 100) begin step(); n++; end
      check({tag, " on_len"}, n, 30);
      check({tag, " dark_num"}, 32'(simonNum), 0);
      n = 0;
      while (!simonPressed && simonTurn && n < 100) begin step(); n++; end
      check({tag, " off_len"}, n, 15);
    end
    check({tag, " turn_end"}, 32'(simonTurn), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; randNum = 2'd0; playerNum = 2'd0; playerPressed = 1'b0;
    step(); step();
    check("rst_turn", 32'(simonTurn), 0);
    check("rst_pressed", 32'(simonPressed), 0);
    check("rst_num", 32'(simonNum), 0);
    check("rst_level", 32'(level), 0);
    check("rst_over", 32'(gameOver), 0);
    check("rst_win", 32'(win), 0);
    reset = 1'b0;
    step();

    // First game: one ADD cycle, then step 2 is shown.
    randNum = 2'd2; seqQ.push_back(2'd2);
    start = 1'b1; step(); start = 1'b0;
    check("add_dark", 32'(simonPressed), 0);
    check("add_level", 32'(level), 0);
    step();
    check("first_lit", 32'(simonPressed), 1);
    check("level1", 32'(level), 1);
    watchShow("L1");

    // Correct press at level 1; next step will be 1.
    playerNum = 2'd2; playerPressed = 1'b1; step();
    randNum = 2'd1; seqQ.push_back(2'd1); playerPressed = 1'b0; step();
    // Hold a wrong button through the whole replay.
    playerNum = 2'd3; playerPressed = 1'b1; step();
    check("level2", 32'(level), 2);
    watchShow("L2");
    repeat (5) step();
    check("held_no_eval", 32'(gameOver), 0);
    check("held_wait", 32'(simonTurn), 0);
    check("held_no_eval2", 32'(s2Over), 0);
    playerPressed = 1'b0; step();

    playerNum = 2'd2; playerPressed = 1'b1; step(); playerPressed = 1'b0; step();
    playerNum = 2'd1; playerPressed = 1'b1; step();
    randNum = 2'd0; seqQ.push_back(2'd0); playerPressed = 1'b0; step();
    check("win2", 32'(s2Win), 1);
    check("win2_level", 32'(s2Level), 2);
    check("win2_over", 32'(s2Over), 0);
    check("nowin", 32'(win), 0);
    step();
    check("level3", 32'(level), 3);
    watchShow("L3");

    // Correct first step, wrong second step.
    playerNum = 2'd2; playerPressed = 1'b1; step(); playerPressed = 1'b0; step();
    playerNum = 2'd3; playerPressed = 1'b1; step();
    check("over_next", 32'(gameOver), 1);
    check("over_turn", 32'(simonTurn), 0);
    playerPressed = 1'b0; step();
    check("over_hold", 32'(gameOver), 1);
    check("over_level", 32'(level), 3);

    // Restart from GAME_OVER.
    seqQ.delete();
    randNum = 2'd3; seqQ.push_back(2'd3);
    start = 1'b1; step(); start = 1'b0;
    check("restart_level", 32'(level), 0);
    check("restart_over", 32'(gameOver), 0);
    step();
    watchShow("R1");
    check("restart_level1", 32'(level), 1);

    // start while waiting for the player is ignored.
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("ign_turn", 32'(simonTurn), 0);
    check("ign_lit", 32'(simonPressed), 0);
    check("ign_level", 32'(level), 1);

    // Reset in the middle of a lit step.
    playerNum = 2'd3; playerPressed = 1'b1; step();
    randNum = 2'd1; playerPressed = 1'b0; step();
    n = 0;
    while (!simonPressed && n < 10) begin step(); n++; end
    check("mid_lit", 32'(simonPressed), 1);
    repeat (5) step();
    reset = 1'b1; step();
    check("mid_rst_turn", 32'(simonTurn), 0);
    check("mid_rst_pressed", 32'(simonPressed), 0);
    check("mid_rst_num", 32'(simonNum), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_over", 32'(gameOver), 0);
    check("mid_rst_win2", 32'(s2Win), 0);
    check("mid_rst_level2", 32'(s2Level), 0);
    reset = 1'b0; step();

    // Idle player after the replay.
    seqQ.delete();
    randNum = 2'd0; seqQ.push_back(2'd0);
    start = 1'b1; step(); start = 1'b0; step();
    watchShow("T1");
    n = 0;
`ifdef SIMON_TIMEOUT_EN
    while (!gameOver && n < 400) begin step(); n++; end
    check("timeout_cycles", n, 180);
    check("timeout_over", 32'(gameOver), 1);
`else
    repeat (300) begin step(); n++; end
    check("no_timeout_over", 32'(gameOver), 0);
    check("no_timeout_turn", 32'(simonTurn), 0);
    check("no_timeout_level", 32'(level), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simon_seq_ctrl.md
SIMON_SEQ_CTRL -- requirements
Module: simon_seq_ctrl

Interface
REQ-001 Parameter MAX_LEN, 32, maximum sequence length (steps); legal range 2..32.
REQ-002 Parameter ON_TICKS, 30, clock cycles each Simon step is shown lit.
REQ-003 Parameter OFF_TICKS, 15, clock cycles of dark gap after each shown step.
REQ-004 Parameter TIMEOUT_TICKS, 180, player inactivity limit in cycles (used only under SIMON_TIMEOUT_EN).
REQ-005 clk  in  1  60 Hz game clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse: begin new game.
REQ-008 rand  in  2  random color, sampled when a step is appended.
REQ-009 playerNum  in  2  color of player's button.
REQ-010 playerPressed  in  1  level, high while player holds a button.
REQ-011 simonTurn  out  1  high while Simon plays the sequence.
REQ-012 simonNum  out  2  color currently shown; 0 outside SHOW_ON.
REQ-013 simonPressed  out  1  high while a step is lit.
REQ-014 level  out  6  current sequence length (0..MAX_LEN).
REQ-015 gameOver  out  1  high in GAME_OVER.
REQ-016 win  out  1  high in WIN.

Function
REQ-017 FSM states SHALL be IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_PRESS, WAIT_RELEASE, GAME_OVER, WIN.
REQ-018 IDLE/GAME_OVER/WIN: start SHALL clear level to 0 and go to ADD next cycle.
REQ-019 ADD: one cycle; SHALL write rand to entry level, increment level, clear step index and tick counter, go to SHOW_ON.
REQ-020 SHOW_ON: simonTurn=1, simonPressed=1, simonNum=entry[idx]; after exactly ON_TICKS cycles go to SHOW_OFF.
REQ-021 SHOW_OFF: simonTurn=1, simonPressed=0; after OFF_TICKS cycles, if idx==level-1 go to WAIT_PRESS with idx=0, else idx+1 and SHOW_ON.
REQ-022 WAIT_PRESS: simonTurn=0; a press SHALL be a rising edge of playerPressed (registered previous value low, current high).
REQ-023 On press, playerNum==entry[idx] SHALL go to WAIT_RELEASE; mismatch SHALL go to GAME_OVER the next cycle.
REQ-024 WAIT_RELEASE: when playerPressed low, if idx<level-1 then idx+1 and WAIT_PRESS; else WIN if level==MAX_LEN, otherwise ADD.
REQ-025 playerPressed activity during SHOW_ON/SHOW_OFF SHALL be ignored; a button held into WAIT_PRESS SHALL NOT count until released and re-pressed.
REQ-026 start outside IDLE/GAME_OVER/WIN SHALL be ignored.
REQ-027 Tick counter SHALL be wide enough for max(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS) and never wrap within a state.

Reset
REQ-028 reset SHALL force IDLE, level=0, idx=0, counters=0, edge register=0; all outputs 0 the cycle after reset is sampled, including mid-sequence.
REQ-029 Sequence storage contents need not be cleared; only entries < level are ever read.

Configuration
REQ-030 Macro SIMON_TIMEOUT_EN defined: a counter running in WAIT_PRESS (cleared on entry) SHALL force GAME_OVER when it reaches TIMEOUT_TICKS without a press.
REQ-031 Macro undefined: no timeout logic; WAIT_PRESS waits indefinitely.

Structure
REQ-032 Shared package simon_pkg SHALL hold the color typedef (2-bit), the FSM state enum and default timing constants.
REQ-033 Sub-module simon_seq_mem: MAX_LEN x 2-bit register file, synchronous write, combinational read.

Verification
REQ-034 reset, start, rand=2 -> after 1 ADD cycle, simonPressed high 30 cycles with simonNum=2, low 15 cycles, then simonTurn=0.
REQ-035 Level 1 entry 2; press playerNum=2, release -> level=2, new step appended, replay of 2 steps.
REQ-036 Level 2 sequence {2,1}; press 2 then 3 -> gameOver=1 next cycle; start -> level reset, new game.
REQ-037 playerPressed held high through SHOW_OFF into WAIT_PRESS -> no evaluation until release and re-press.
REQ-038 MAX_LEN=2, all presses correct -> win=1 after second release at level 2.
REQ-039 SIMON_TIMEOUT_EN, TIMEOUT_TICKS=180, no press -> gameOver=1 exactly 180 cycles after WAIT_PRESS entry; reset asserted mid-SHOW_ON -> all outputs 0 next cycle.
